// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned INSTR_W = 32;

   localparam logic [5:0]      OP_CALL = 6'b001001;
   localparam logic [PC_W-1:0] PC_INC  = 32'd4;

   typedef enum logic [1:0] {
      StResetWait = 2'd0,
      StFetch     = 2'd1,
      StResolve   = 2'd2,
      StHalted    = 2'd3
   } pc_state_e;

   // Instruction addresses are word aligned; low two bits are always dropped.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [Width-1:0] push_data_i,
   output logic [Width-1:0] top_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  top_q;
   logic [PtrW-1:0]  top_nxt;
   logic [PtrW-1:0]  top_prv;
   logic [CntW-1:0]  cnt_q;

   always_comb begin
      top_nxt = (top_q == PtrW'(Depth - 1)) ? '0 : top_q + PtrW'(1);
      top_prv = (top_q == '0) ? PtrW'(Depth - 1) : top_q - PtrW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
         top_q <= '0;
         cnt_q <= '0;
      end else if (push_i) begin
         mem_q[top_nxt] <= push_data_i;
         top_q          <= top_nxt;
         if (cnt_q != CntW'(Depth)) begin
            cnt_q <= cnt_q + CntW'(1);
         end
      end else if (pop_i && (cnt_q != '0)) begin
         top_q <= top_prv;
         cnt_q <= cnt_q - CntW'(1);
      end
   end

   assign top_o   = mem_q[top_q];
   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CntW'(Depth));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/resolve program-counter sequencer. Optional macro PC_RAS_EN replaces the single
// link register with a RAS_DEPTH-entry return-address stack.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned     RAS_DEPTH    = 4
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imemReq,
   output logic [PC_W-1:0]    imemAddr,
   input  logic               imemValid,
   input  logic [INSTR_W-1:0] imemData,
   output logic [INSTR_W-1:0] instrOut,
   output logic               instrValid,
   input  logic               resolveValid,
   input  logic               jumpValidity,
   input  logic [PC_W-1:0]    jumpTarget,
   input  logic               isCall,
   input  logic               isReturn,
   input  logic               haltReq,
   input  logic               stall,
   output logic [PC_W-1:0]    pc,
   output logic [PC_W-1:0]    linkAddr,
   output logic               halted
);

   if (RAS_DEPTH == 0) begin : g_bad_depth
      $fatal(1, "RAS_DEPTH must be at least 1");
   end

   pc_state_e          state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               instr_valid_q, instr_valid_d;

   logic            accept;
   logic            resolve;
   logic            do_push;
   logic            do_pop;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] ret_target;

   assign accept  = (state_q == StFetch) && imemValid && !stall;
   assign resolve = (state_q == StResolve) && resolveValid && !stall;
   // Halt suppresses every side effect; return outranks call.
   assign do_pop  = resolve && !haltReq && isReturn;
   assign do_push = resolve && !haltReq && !isReturn && jumpValidity && isCall;
   assign pc_inc  = pc_q + PC_INC;

`ifdef PC_RAS_EN
   logic [PC_W-1:0] ras_top;
   logic            ras_empty;

   ras_stack #(
      .Depth (RAS_DEPTH),
      .Width (PC_W)
   ) u_ras (
      .clk         (clk),
      .rst         (rst),
      .push_i      (do_push),
      .pop_i       (do_pop),
      .push_data_i (pc_inc),
      .top_o       (ras_top),
      .empty_o     (ras_empty),
      .full_o      ()
   );

   assign ret_target = ras_empty ? RESET_VECTOR : ras_top;
   assign linkAddr   = ras_empty ? '0 : ras_top;
`else
   logic [PC_W-1:0] link_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         link_q <= '0;
      end else if (do_push) begin
         link_q <= pc_inc;
      end
   end

   assign ret_target = link_q;
   assign linkAddr   = link_q;
`endif

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = 1'b0;
      unique case (state_q)
         StResetWait: state_d = StFetch;
         StFetch: begin
            if (accept) begin
               instr_d       = imemData;
               instr_valid_d = 1'b1;
               state_d       = StResolve;
            end
         end
         StResolve: begin
            if (resolve) begin
               if (haltReq) begin
                  state_d = StHalted;
               end else begin
                  state_d = StFetch;
                  if (isReturn) begin
                     pc_d = align_pc(ret_target);
                  end else if (jumpValidity) begin
                     pc_d = align_pc(jumpTarget);
                  end else begin
                     pc_d = pc_inc;
                  end
               end
            end
         end
         StHalted: state_d = StHalted;
         default:  state_d = StResetWait;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StResetWait;
         pc_q          <= RESET_VECTOR;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   assign imemReq    = (state_q == StFetch);
   assign imemAddr   = pc_q;
   assign pc         = pc_q;
   assign instrOut   = instr_q;
   assign instrValid = instr_valid_q;
   assign halted     = (state_q == StHalted);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded at reset.
REQ-003 Parameter RAS_DEPTH, default 4: return-stack entries; used only when PC_RAS_EN is defined.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 imemReq  out  1  instruction fetch request.
REQ-007 imemAddr  out  32  fetch address; always equal to pc.
REQ-008 imemValid  in  1  fetch data valid; qualifies imemData.
REQ-009 imemData  in  32  fetched instruction word.
REQ-010 instrOut  out  32  last fetched instruction, held until the next fetch.
REQ-011 instrValid  out  1  one-cycle pulse when instrOut updates.
REQ-012 resolveValid  in  1  downstream branch resolution valid; qualifies the five inputs below.
REQ-013 jumpValidity  in  1  branch taken, from the jump-control stage.
REQ-014 jumpTarget  in  32  branch target byte address.
REQ-015 isCall  in  1  taken branch is a call (opcode 6'b001001); pushes the link.
REQ-016 isReturn  in  1  return; target comes from the link/stack.
REQ-017 haltReq  in  1  halt instruction resolved.
REQ-018 stall  in  1  hold the current state; no PC update.
REQ-019 pc  out  32  current program counter.
REQ-020 linkAddr  out  32  most recent link (top of stack when PC_RAS_EN is defined).
REQ-021 halted  out  1  high in HALTED.

Function
REQ-022 FSM states: RESET_WAIT, FETCH, RESOLVE, HALTED.
REQ-023 RESET_WAIT: outputs idle; unconditionally enters FETCH on the next clock.
REQ-024 FETCH: imemReq=1. On imemValid: instrOut<=imemData, instrValid=1 next cycle, state<=RESOLVE. Fetch latency is unbounded.
REQ-025 imemValid outside FETCH is ignored.
REQ-026 RESOLVE: imemReq=0. Wait for resolveValid&!stall; PC updates on that edge, then state<=FETCH.
REQ-027 Next-PC priority:
- haltReq: go to HALTED, pc unchanged.
- isReturn: pc<=link.
- jumpValidity: pc<=jumpTarget.
- otherwise: pc<=pc+4.
REQ-028 jumpTarget[1:0] and the link low bits SHALL be forced to 2'b00 when loaded into pc.
REQ-029 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-030 isCall&jumpValidity SHALL record link=pc+4.
REQ-031 isCall together with isReturn: the return wins; no push.
REQ-032 isCall without jumpValidity has no effect.
REQ-033 stall high SHALL freeze state, pc and the link in every state except RESET_WAIT.
REQ-034 HALTED: imemReq=0, halted=1; exit only by reset.

Reset
REQ-035 Asserting rst at any time, including mid-fetch, SHALL immediately set:
- pc=RESET_VECTOR, state=RESET_WAIT
- imemReq=0, instrValid=0, instrOut=0
- linkAddr=0, halted=0
- return stack empty.

Configuration
REQ-036 Macro PC_RAS_EN.
- Defined: a RAS_DEPTH-entry return-address stack. A call pushes; a return pops. Push when full overwrites the oldest entry. Pop when empty yields RESET_VECTOR. linkAddr = top entry, or 0 when empty.
- Undefined: a single link register. A call overwrites it; a return reads it without clearing.

Structure
REQ-037 Package pc_seq_pkg SHALL hold:
- state enum
- PC_W=32, INSTR_W=32
- OP_CALL=6'b001001
- PC_INC=4.
REQ-038 Sub-module ras_stack (push, pop, top, empty, full) SHALL be instantiated only under PC_RAS_EN.

Verification
REQ-039 Reset, imemValid after 3 cycles with data 32'h1234_5678, then resolveValid, jumpValidity=0 -> imemAddr=0, instrOut=32'h1234_5678 with a single-cycle instrValid, next pc=4.
REQ-040 pc=32'h10, jumpValidity=1, jumpTarget=32'h0000_0103 -> pc=32'h100 (low bits cleared).
REQ-041 Call at pc=32'h20 to 32'h80, then return -> linkAddr=32'h24, pc=32'h24. With PC_RAS_EN: 5 nested calls, depth 4, then 5 returns -> 4 correct returns, fifth pc=RESET_VECTOR.
REQ-042 stall held 4 cycles in RESOLVE with resolveValid=1 -> pc unchanged; updates on the first cycle after stall falls.
REQ-043 haltReq -> halted=1, imemReq stays 0 for 10 cycles; rst -> pc=RESET_VECTOR, halted=0.
REQ-044 rst asserted mid-FETCH at pc=32'hFFFF_FFFC; separately, no-branch resolve at pc=32'hFFFF_FFFC -> reset clears all state immediately; resolve wraps pc to 32'h0.
